// File: rtl/maze_renderer.sv
// Maze pixel generator (2-stage RGB565 pipeline) plus wall-checked player movement engine.
// Optional visited-cell trail rendering is compiled in with `define MAZE_TRAIL_EN.
module maze_renderer #(
    parameter int          SCR_W        = 96,
    parameter int          SCR_H        = 64,
    parameter int          CELL         = 8,
    parameter int          GRID_W       = SCR_W / CELL,
    parameter int          GRID_H       = SCR_H / CELL,
    parameter int          IDX_W        = 13,
    parameter int          START_X      = 0,
    parameter int          START_Y      = 0,
    parameter int          GOAL_X       = 11,
    parameter int          GOAL_Y       = 7,
    parameter logic [15:0] WALL_COLOR   = 16'hFFFF,
    parameter logic [15:0] PATH_COLOR   = 16'h0000,
    parameter logic [15:0] PLAYER_COLOR = 16'hF800,
    parameter logic [15:0] GOAL_COLOR   = 16'h07E0,
    parameter logic [15:0] TRAIL_COLOR  = 16'h001F
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IDX_W-1:0]            index,
    output logic [15:0]                 data,
    input  logic                        map_we,
    input  logic [$clog2(GRID_H)-1:0]   map_row,
    input  logic [GRID_W-1:0]           map_data,
    input  logic                        move_valid,
    input  logic [1:0]                  move_dir,
    output logic                        move_ready,
    output logic [$clog2(GRID_W)-1:0]   player_x,
    output logic [$clog2(GRID_H)-1:0]   player_y,
    output logic                        at_goal,
    output logic                        bump
);
    localparam int CW = $clog2(GRID_W);
    localparam int RW = $clog2(GRID_H);
    localparam logic START_AT_GOAL = (START_X == GOAL_X) && (START_Y == GOAL_Y);

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

    logic [GRID_W-1:0] wall [GRID_H];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < GRID_H; r++) wall[r] <= '0;
        end else if (map_we && int'(map_row) < GRID_H) begin
            wall[map_row] <= map_data;
        end
    end

`ifdef MAZE_TRAIL_EN
    logic [GRID_W-1:0] visited [GRID_H];
`endif

    // ---------------- render pipeline ----------------
    logic [IDX_W-1:0] px, py;
    logic [CW-1:0]    s1_col;
    logic [RW-1:0]    s1_row;
    logic             s1_in;
    logic [15:0]      color;

    assign px = IDX_W'(int'(index) % SCR_W);
    assign py = IDX_W'(int'(index) / SCR_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_col <= '0;
            s1_row <= '0;
            s1_in  <= 1'b0;
        end else begin
            s1_col <= CW'(int'(px) / CELL);
            s1_row <= RW'(int'(py) / CELL);
            s1_in  <= int'(index) < SCR_W * SCR_H;
        end
    end

    always_comb begin
        color = PATH_COLOR;
        if (!s1_in)
            color = PATH_COLOR;
        else if (s1_col == player_x && s1_row == player_y)
            color = PLAYER_COLOR;
        else if (s1_col == CW'(GOAL_X) && s1_row == RW'(GOAL_Y))
            color = GOAL_COLOR;
`ifdef MAZE_TRAIL_EN
        else if (visited[s1_row][s1_col])
            color = TRAIL_COLOR;
`endif
        else if (wall[s1_row][s1_col])
            color = WALL_COLOR;
    end

    always_ff @(posedge clk) begin
        if (reset) data <= '0;
        else       data <= color;
    end

    // ---------------- move engine ----------------
    state_t        state, state_nx;
    logic [CW-1:0] nx_x, tgt_x;
    logic [RW-1:0] nx_y, tgt_y;
    logic          nx_off, tgt_off;
    logic          accept, reject;

    assign accept = move_valid && move_ready;
    assign reject = tgt_off || wall[tgt_y][tgt_x];

    // Off-grid targets keep the current cell so the wall lookup stays in range.
    always_comb begin
        nx_x   = player_x;
        nx_y   = player_y;
        nx_off = 1'b0;
        case (move_dir)
            2'd0: if (player_y == '0) nx_off = 1'b1; else nx_y = player_y - RW'(1);
            2'd1: if (int'(player_x) == GRID_W - 1) nx_off = 1'b1; else nx_x = player_x + CW'(1);
            2'd2: if (int'(player_y) == GRID_H - 1) nx_off = 1'b1; else nx_y = player_y + RW'(1);
            default: if (player_x == '0) nx_off = 1'b1; else nx_x = player_x - CW'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CHECK;
            CHECK:   state_nx = reject ? IDLE : COMMIT;
            default: state_nx = IDLE;
        endcase
    end

    // The bump cycle also holds off requests, keeping every move at three cycles.
    always_comb begin
        move_ready = (state == IDLE) && !at_goal && !bump;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_x    <= '0;
            tgt_y    <= '0;
            tgt_off  <= 1'b0;
            bump     <= 1'b0;
            player_x <= CW'(START_X);
            player_y <= RW'(START_Y);
            at_goal  <= START_AT_GOAL;
        end else begin
            bump <= (state == CHECK) && reject;
            if (accept) begin
                tgt_x   <= nx_x;
                tgt_y   <= nx_y;
                tgt_off <= nx_off;
            end
            if (state == COMMIT) begin
                player_x <= tgt_x;
                player_y <= tgt_y;
                at_goal  <= (tgt_x == CW'(GOAL_X)) && (tgt_y == RW'(GOAL_Y));
            end
        end
    end

`ifdef MAZE_TRAIL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < GRID_H; r++)
                visited[r] <= (r == START_Y) ? (GRID_W'(1) << START_X) : '0;
        end else if (state == COMMIT) begin
            visited[tgt_y][tgt_x] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_maze_renderer.sv
// Directed bench for maze_renderer: render priorities, wall bumps, map/CHECK race, reset, goal lock.
module tb_maze_renderer;
    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] index;
    logic [15:0] data;
    logic        map_we;
    logic [2:0]  map_row;
    logic [11:0] map_data;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic [3:0]  player_x;
    logic [2:0]  player_y;
    logic        at_goal;
    logic        bump;

    int n_pass = 0;
    int n_chk  = 0;

    maze_renderer dut (
        .clk(clk), .reset(reset), .index(index), .data(data),
        .map_we(map_we), .map_row(map_row), .map_data(map_data),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .player_x(player_x), .player_y(player_y), .at_goal(at_goal), .bump(bump)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input int idx, input int exp);
        index = 13'(idx);
        tick();
        tick();
        chk(tag, int'(data), exp);
    endtask

    task automatic wr_row(input int row, input int bits);
        map_we = 1'b1; map_row = 3'(row); map_data = 12'(bits);
        tick();
        map_we = 1'b0;
    endtask

    // Issue one move and check ready/bump/position over its three cycles.
    task automatic mv(input string tag, input int dir, input int exp_bump, input int ex, input int ey);
        chk({tag, " ready_pre"}, int'(move_ready), 1);
        move_valid = 1'b1; move_dir = 2'(dir);
        tick();
        move_valid = 1'b0;
        chk({tag, " ready_n1"}, int'(move_ready), 0);
        chk({tag, " bump_n1"}, int'(bump), 0);
        tick();
        chk({tag, " ready_n2"}, int'(move_ready), 0);
        chk({tag, " bump_n2"}, int'(bump), exp_bump);
        tick();
        chk({tag, " bump_done"}, int'(bump), 0);
        chk({tag, " x"}, int'(player_x), ex);
        chk({tag, " y"}, int'(player_y), ey);
        chk({tag, " goal"}, int'(at_goal), (ex == 11 && ey == 7) ? 1 : 0);
    endtask

    initial begin
        reset = 1'b1; index = '0; map_we = 1'b0; map_row = '0; map_data = '0;
        move_valid = 1'b0; move_dir = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst data", int'(data), 0);
        chk("rst ready", int'(move_ready), 1);
        chk("rst x", int'(player_x), 0);
        chk("rst y", int'(player_y), 0);
        chk("rst goal", int'(at_goal), 0);
        chk("rst bump", int'(bump), 0);

        pix("pix player", 0, 16'hF800);
        pix("pix path", 95, 16'h0000);
        pix("pix goal", 5464, 16'h07E0);
        pix("pix oor", 6144, 16'h0000);

        // Back-to-back pixels: one result per clock, two cycles behind index.
        index = 13'd5464; tick();
        index = 13'd0;    tick();
        chk("pipe a", int'(data), 16'h07E0);
        index = 13'd95;   tick();
        chk("pipe b", int'(data), 16'hF800);
        tick();
        chk("pipe c", int'(data), 16'h0000);

        wr_row(0, 12'h002);
        mv("wall right", 1, 1, 0, 0);
        pix("pix wall", 8, 16'hFFFF);
        wr_row(7, 12'h800);
        pix("pix goal over wall", 5464, 16'h07E0);
        wr_row(0, 0);
        wr_row(7, 0);

        mv("down", 2, 0, 0, 1);
        mv("up", 0, 0, 0, 0);
        mv("edge up", 0, 1, 0, 0);
        mv("edge left", 3, 1, 0, 0);

        // Reset lands on the CHECK edge of a doomed move.
        move_valid = 1'b1; move_dir = 2'd0;
        tick();
        move_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstchk bump", int'(bump), 0);
        chk("rstchk ready", int'(move_ready), 1);
        chk("rstchk x", int'(player_x), 0);
        chk("rstchk y", int'(player_y), 0);
        tick();
        chk("rstchk bump2", int'(bump), 0);

        // Wall written on the CHECK edge is not seen; player then sits on a wall.
        move_valid = 1'b1; move_dir = 2'd1;
        tick();
        move_valid = 1'b0; map_we = 1'b1; map_row = 3'd0; map_data = 12'h002;
        tick();
        map_we = 1'b0;
        chk("race bump", int'(bump), 0);
        tick();
        chk("race x", int'(player_x), 1);
        chk("race y", int'(player_y), 0);
        pix("pix player on wall", 8, 16'hF800);
        wr_row(0, 0);

        mv("down11", 2, 0, 1, 1);
        for (int i = 2; i <= 11; i++) mv("walk r", 1, 0, i, 1);
        for (int j = 2; j <= 7; j++) mv("walk d", 2, 0, 11, j);
        chk("goal ready", int'(move_ready), 0);
        move_valid = 1'b1; move_dir = 2'd3;
        tick(); tick(); tick();
        move_valid = 1'b0;
        chk("goal hold x", int'(player_x), 11);
        chk("goal hold y", int'(player_y), 7);
        chk("goal hold bump", int'(bump), 0);
        chk("goal hold ready", int'(move_ready), 0);
        pix("pix goal player", 5464, 16'hF800);
        pix("pix unvisited", 2344, 16'h0000);
`ifdef MAZE_TRAIL_EN
        pix("pix trail", 8, 16'h001F);
        pix("pix start trail", 95, 16'h0000);
        pix("pix start cell", 0, 16'h001F);
`else
        pix("pix trail", 8, 16'h0000);
        pix("pix start cell", 0, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/maze_renderer.md
# maze_renderer

Parametrised maze pixel generator with a player-movement engine for the OLED display path. It holds a runtime-loadable wall map (one bit per grid cell) instead of a hard-wired layout. It converts a raster pixel index into a 16-bit RGB565 colour through a 2-stage pipeline, and overlays a player marker and a goal marker. It also accepts direction requests, checks them against the wall map, and reports bumps and goal arrival to the game controller.

## Interface
Parameters:
- SCR_W, 96, screen width in pixels
- SCR_H, 64, screen height in pixels
- CELL, 8, cell edge in pixels; must be a power of two
- GRID_W, SCR_W/CELL (12), grid columns
- GRID_H, SCR_H/CELL (8), grid rows
- IDX_W, 13, pixel index width
- START_X, START_Y, 0, 0: player reset cell
- GOAL_X, GOAL_Y, 11, 7: goal cell
- WALL_COLOR, 16'hFFFF; PATH_COLOR, 16'h0000; PLAYER_COLOR, 16'hF800; GOAL_COLOR, 16'h07E0; TRAIL_COLOR, 16'h001F

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- Reset rule (already decided): one clock; reset is synchronous and active-high.
- index  in  IDX_W  pixel index; x = index % SCR_W, y = index / SCR_W
- data  out  16  RGB565 colour for the index presented 2 cycles earlier
- map_we  in  1  wall-map row write strobe
- map_row  in  $clog2(GRID_H)  row to write
- map_data  in  GRID_W  bit c = 1 means cell (c, map_row) is a wall
- move_valid  in  1  direction request
- move_dir  in  2  00 up (y−1), 01 right (x+1), 10 down (y+1), 11 left (x−1)
- move_ready  out  1  engine can accept a request
- player_x  out  $clog2(GRID_W)  current player column
- player_y  out  $clog2(GRID_H)  current player row
- at_goal  out  1  player is on the goal cell
- bump  out  1  one-cycle pulse when a move is rejected

## Operation
Wall map:
- GRID_H × GRID_W register array; reset clears every cell to open.
- When map_we = 1 and map_row < GRID_H, the row is overwritten on that edge.
- When map_row ≥ GRID_H, the write is ignored.

Render pipeline:
- Stage 1 registers the cell column, cell row and an in-range flag (index < SCR_W*SCR_H).
- Stage 2 registers data using fixed priority: out-of-range → PATH_COLOR; player cell → PLAYER_COLOR; goal cell → GOAL_COLOR; visited cell → TRAIL_COLOR (only when compiled in); wall → WALL_COLOR; otherwise PATH_COLOR.
- Stage 2 uses the map, position and trail values current at that edge.

Move FSM states:
- IDLE: move_ready = !at_goal. On move_valid && move_ready, latch the target cell and go to CHECK.
- CHECK: if the target is off-grid or a wall, pulse bump for one cycle and return to IDLE. Otherwise go to COMMIT.
- COMMIT: write the target into player_x/player_y, update at_goal, return to IDLE.

Boundary rules:
- A map write landing on the CHECK edge is not seen by CHECK; CHECK uses the pre-write value.
- A player standing on a cell that later becomes a wall stays in place, and the player colour still wins priority.
- When at_goal = 1, move_ready stays 0 until reset.
- Reset in any state returns the FSM to IDLE, restores START_X/START_Y, clears bump, and discards any pending move.

## Timing
Reset values:
- data = 0
- move_ready = 1, unless START equals GOAL
- player = (START_X, START_Y)
- at_goal = (START == GOAL)
- bump = 0
- FSM in IDLE

Latencies:
- data has 2 cycles of latency from index and supports full throughput, one pixel per clock.
- A move is accepted at edge N. move_ready is 0 during cycles N+1 and N+2.
- bump is high during cycle N+1→N+2 (the CHECK result).
- The new position and at_goal are visible after edge N+2.
- move_ready returns to 1 after edge N+2, giving at most one move per 3 cycles.

## Configuration
- MAZE_TRAIL_EN defined:
  - A GRID_H × GRID_W visited array is built.
  - Reset marks only the START cell as visited.
  - Each COMMIT marks the new cell as visited.
  - Visited, non-player, non-goal cells render TRAIL_COLOR, even if the cell is now a wall.
- MAZE_TRAIL_EN undefined: no visited array and no TRAIL_COLOR output; all other behaviour is identical.

## Test plan
- After reset, drive index=0 → data=16'hF800 two cycles later. index=95 → 16'h0000. index=5464 (cell 11,7) → 16'h07E0. index=6144 (out of range) → 16'h0000.
- Write map_row=0, map_data=12'h002, then request move right from (0,0): bump=1 for one cycle, position stays (0,0). index=8 → 16'hFFFF.
- Move down from (0,0) on an open map: move_ready is low for 2 cycles, then player=(0,1). Immediately issue move up: player=(0,0).
- Move up or left at (0,0): bump pulses and the position is unchanged. Assert reset during CHECK: no bump, player=(0,0), move_ready=1.
- Walk an open map to (11,7): at_goal=1, move_ready=0, further move_valid is ignored. index=5464 → 16'hF800.
- With MAZE_TRAIL_EN defined, move right then down to (1,1): index=8 (cell 1,0) → 16'h001F. Without the macro, the same pixel → 16'h0000.
